// File: rtl/gmii_rx_axis_if.sv
// rtl/gmii_rx_axis_if.sv - AXI-Stream byte channel produced by the GMII receive framer
interface gmii_rx_axis_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/gmii_rx_axis.sv
// rtl/gmii_rx_axis.sv - GMII/MII receive framer: strips preamble/SFD, checks and drops FCS
module gmii_rx_axis #(
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [7:0]     gmii_rxd,
    input  logic           gmii_rx_dv,
    input  logic           gmii_rx_er,
    input  logic           clk_en_i,
    input  logic           mii_select_i,
    gmii_rx_axis_if.master m_axis,
    output logic           start_packet_o,
    output logic           error_bad_frame_o,
    output logic           error_bad_fcs_o
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LENGTH);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_DISCARD} state_t;

    state_t          state;
    logic [7:0]      rxd_q;
    logic            dv_q, er_q, en_q, mii_q;
    logic [3:0]      nib_lo;
    logic            nib_pending;
    logic [31:0]     crc;
    logic [15:0]     byte_cnt;
    logic            er_seen;
    logic [4:0][7:0] dline;

    logic            sym_pre, sym_sfd, fcs_bad, line_full, frame_bad;
    logic [7:0]      byte_val;
    logic [31:0]     crc_next;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // In MII mode a byte is the pending low nibble joined with the current high nibble.
    always_comb begin
        sym_pre   = mii_q ? (rxd_q[3:0] == 4'h5) : (rxd_q == 8'h55);
        sym_sfd   = mii_q ? (rxd_q[3:0] == 4'hD) : (rxd_q == 8'hD5);
        byte_val  = mii_q ? {rxd_q[3:0], nib_lo} : rxd_q;
        crc_next  = crc_byte(crc, byte_val);
        fcs_bad   = (crc != CRC_RESIDUE);
        line_full = (byte_cnt >= 16'd5);
        frame_bad = er_seen || fcs_bad || (byte_cnt < MIN_LEN) || nib_pending;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state             <= S_IDLE;
            rxd_q             <= 8'd0;
            dv_q              <= 1'b0;
            er_q              <= 1'b0;
            en_q              <= 1'b0;
            mii_q             <= 1'b0;
            nib_lo            <= 4'd0;
            nib_pending       <= 1'b0;
            crc               <= 32'hFFFFFFFF;
            byte_cnt          <= 16'd0;
            er_seen           <= 1'b0;
            dline             <= '0;
            m_axis.tdata      <= 8'd0;
            m_axis.tvalid     <= 1'b0;
            m_axis.tlast      <= 1'b0;
            m_axis.tuser      <= 1'b0;
            start_packet_o    <= 1'b0;
            error_bad_frame_o <= 1'b0;
            error_bad_fcs_o   <= 1'b0;
        end else begin
            m_axis.tvalid     <= 1'b0;
            m_axis.tlast      <= 1'b0;
            m_axis.tuser      <= 1'b0;
            start_packet_o    <= 1'b0;
            error_bad_frame_o <= 1'b0;
            error_bad_fcs_o   <= 1'b0;

            if (clk_en_i) begin
                rxd_q <= gmii_rxd;
                dv_q  <= gmii_rx_dv;
                er_q  <= gmii_rx_er;
            end
            en_q <= clk_en_i;
            if (state == S_IDLE) mii_q <= mii_select_i;

            // A captured sample is consumed on the clock right after its enabled capture edge.
            if (en_q) begin
                case (state)
                    S_IDLE, S_PREAMBLE: begin
                        if (!dv_q) begin
                            state <= S_IDLE;
                        end else if (sym_sfd) begin
                            state          <= S_PAYLOAD;
                            start_packet_o <= 1'b1;
                            crc            <= 32'hFFFFFFFF;
                            byte_cnt       <= 16'd0;
                            er_seen        <= 1'b0;
                            nib_pending    <= 1'b0;
                        end else if (sym_pre) begin
                            state <= S_PREAMBLE;
                        end else begin
                            state <= S_DISCARD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (dv_q) begin
                            if (er_q) er_seen <= 1'b1;
                            if (mii_q && !nib_pending) begin
                                nib_lo      <= rxd_q[3:0];
                                nib_pending <= 1'b1;
                            end else begin
                                nib_pending <= 1'b0;
                                crc         <= crc_next;
                                dline       <= {dline[3:0], byte_val};
                                if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                                if (line_full) begin
                                    m_axis.tdata  <= dline[4];
                                    m_axis.tvalid <= 1'b1;
                                end
                            end
                        end else begin
                            // The four youngest entries are the FCS and are dropped here.
                            state             <= S_IDLE;
                            nib_pending       <= 1'b0;
                            error_bad_frame_o <= frame_bad;
                            error_bad_fcs_o   <= fcs_bad;
                            if (line_full) begin
                                m_axis.tdata  <= dline[4];
                                m_axis.tvalid <= 1'b1;
                                m_axis.tlast  <= 1'b1;
                                m_axis.tuser  <= frame_bad;
                            end
                        end
                    end
                    default: begin
                        if (!dv_q) state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gmii_rx_axis.sv
// tb/tb_gmii_rx_axis.sv - randomized self-checking bench for gmii_rx_axis
module tb_gmii_rx_axis;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, clk_en_i, mii_select_i;
    logic       start_packet_o, error_bad_frame_o, error_bad_fcs_o;

    always #5 clk_i = ~clk_i;

    gmii_rx_axis_if m_axis();

    gmii_rx_axis #(.MIN_FRAME_LENGTH(64)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .gmii_rxd          (gmii_rxd),
        .gmii_rx_dv        (gmii_rx_dv),
        .gmii_rx_er        (gmii_rx_er),
        .clk_en_i          (clk_en_i),
        .mii_select_i      (mii_select_i),
        .m_axis            (m_axis),
        .start_packet_o    (start_packet_o),
        .error_bad_frame_o (error_bad_frame_o),
        .error_bad_fcs_o   (error_bad_fcs_o)
    );

    typedef struct packed {logic dv; logic er; logic [7:0] d;} sym_t;

    sym_t       sym_q[$];
    logic [7:0] tx_q[$], exp_q[$], body_q[$];
    int         div = 1;
    bit         mii_mode = 1'b0;
    int         n_chk = 0, n_fail = 0;

    // Observed output log
    logic [7:0] bt_data[$];
    logic       bt_last[$], bt_user[$];
    int         bt_cyc[$];
    int         cyc = 0;
    int         cnt_start = 0, cnt_ef = 0, cnt_fcs = 0, cnt_ef_tl = 0, cnt_fcs_tl = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (m_axis.tvalid === 1'b1) begin
            bt_data.push_back(m_axis.tdata);
            bt_last.push_back(m_axis.tlast);
            bt_user.push_back(m_axis.tuser);
            bt_cyc.push_back(cyc);
        end
        if (start_packet_o === 1'b1) cnt_start <= cnt_start + 1;
        if (error_bad_frame_o === 1'b1) cnt_ef <= cnt_ef + 1;
        if (error_bad_fcs_o === 1'b1) cnt_fcs <= cnt_fcs + 1;
        if (error_bad_frame_o === 1'b1 && m_axis.tlast === 1'b1 && m_axis.tvalid === 1'b1) cnt_ef_tl <= cnt_ef_tl + 1;
        if (error_bad_fcs_o === 1'b1 && m_axis.tlast === 1'b1 && m_axis.tvalid === 1'b1) cnt_fcs_tl <= cnt_fcs_tl + 1;
    end

    // Ethernet FCS: bit-serial CRC-32 over the bytes, LSB first, complemented.
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    task automatic push_sym(input logic dv, input logic er, input logic [7:0] d);
        sym_t s;
        s.dv = dv; s.er = er; s.d = d;
        sym_q.push_back(s);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic er);
        if (mii_mode) begin
            push_sym(1'b1, er, {4'($urandom), b[3:0]});
            push_sym(1'b1, 1'b0, {4'($urandom), b[7:4]});
        end else begin
            push_sym(1'b1, er, b);
        end
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) push_sym(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic build_frame(input logic [7:0] body[$], input bit add_fcs, input int corrupt_idx,
                               input int er_idx, input bit odd_nib, input bit bad_pre);
        logic [7:0]  fr[$];
        logic [31:0] f;
        logic [7:0]  p;
        fr = body;
        if (add_fcs) begin
            f = fcs_of(body);
            for (int k = 0; k < 4; k++) fr.push_back(f[8*k +: 8]);
        end
        if (corrupt_idx >= 0) fr[corrupt_idx] = fr[corrupt_idx] ^ 8'h01;
        tx_q = fr;
        for (int k = 0; k < 8; k++) begin
            p = (k == 7) ? 8'hD5 : ((bad_pre && k == 3) ? 8'h57 : 8'h55);
            push_byte(p, 1'b0);
        end
        foreach (fr[k]) push_byte(fr[k], (k == er_idx));
        if (odd_nib) push_sym(1'b1, 1'b0, 8'($urandom));
    endtask

    // Expected payload is the transmitted frame minus its trailing four FCS bytes.
    task automatic set_exp();
        exp_q.delete();
        for (int k = 0; k + 4 < tx_q.size(); k++) exp_q.push_back(tx_q[k]);
    endtask

    task automatic make_seq(input int n);
        body_q.delete();
        for (int k = 0; k < n; k++) body_q.push_back(8'(k));
    endtask

    task automatic make_rand(input int n);
        body_q.delete();
        for (int k = 0; k < n; k++) body_q.push_back(8'($urandom));
    endtask

    task automatic set_mode(input bit mii);
        mii_mode     = mii;
        div          = mii ? 5 : 1;
        mii_select_i = mii;
    endtask

    task automatic play(input int limit);
        sym_t s;
        int   n;
        n = 0;
        while (sym_q.size() > 0 && (limit < 0 || n < limit)) begin
            s = sym_q.pop_front();
            @(negedge clk_i);
            gmii_rxd = s.d; gmii_rx_dv = s.dv; gmii_rx_er = s.er; clk_en_i = 1'b1;
            for (int k = 1; k < div; k++) begin
                @(negedge clk_i);
                clk_en_i = 1'b0;
            end
            n++;
        end
    endtask

    task automatic run_all();
        add_idle(6);
        play(-1);
        @(posedge clk_i);
        #1;
    endtask

    int mark, s_start, s_ef, s_fcs, s_eftl, s_fcstl;
    int obs_n, obs_bad, obs_gap_bad;
    logic obs_user, obs_last;

    task automatic snap();
        mark = bt_data.size();
        s_start = cnt_start; s_ef = cnt_ef; s_fcs = cnt_fcs; s_eftl = cnt_ef_tl; s_fcstl = cnt_fcs_tl;
    endtask

    task automatic summarize(input int from, input int gap);
        obs_n = 0; obs_bad = 0; obs_gap_bad = 0; obs_user = 1'bx; obs_last = 1'b0;
        for (int i = from; i < bt_data.size(); i++) begin
            obs_n++;
            if (bt_last[i] === 1'b1) begin
                obs_user = bt_user[i];
                obs_last = 1'b1;
                break;
            end
        end
        for (int i = 0; i < obs_n; i++) begin
            if (i >= exp_q.size() || bt_data[from+i] !== exp_q[i]) obs_bad++;
            if (gap > 0 && i > 0 && i < obs_n - 1 && bt_cyc[from+i] - bt_cyc[from+i-1] != gap) obs_gap_bad++;
        end
    endtask

    task automatic test_reset();
        n_chk++; if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset tvalid: got %b want 0", m_axis.tvalid); end
        n_chk++; if (m_axis.tlast !== 1'b0 || m_axis.tuser !== 1'b0) begin n_fail++; $display("FAIL reset tlast/tuser: got %b%b want 00", m_axis.tlast, m_axis.tuser); end
        n_chk++; if (m_axis.tdata !== 8'h00) begin n_fail++; $display("FAIL reset tdata: got %h want 00", m_axis.tdata); end
        n_chk++; if ({start_packet_o, error_bad_frame_o, error_bad_fcs_o} !== 3'b000) begin n_fail++; $display("FAIL reset pulses: got %b want 000", {start_packet_o, error_bad_frame_o, error_bad_fcs_o}); end
    endtask

    task automatic test_gmii_good();
        set_mode(1'b0); make_seq(60); snap();
        build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b0); set_exp(); run_all(); summarize(mark, 1);
        n_chk++; if (obs_n !== 60 || obs_last !== 1'b1) begin n_fail++; $display("FAIL gmii_good beats: got %0d last=%b want 60 last=1", obs_n, obs_last); end
        n_chk++; if (obs_bad !== 0) begin n_fail++; $display("FAIL gmii_good data: got %0d wrong bytes want 0", obs_bad); end
        n_chk++; if (obs_user !== 1'b0) begin n_fail++; $display("FAIL gmii_good tuser: got %b want 0", obs_user); end
        n_chk++; if (obs_gap_bad !== 0) begin n_fail++; $display("FAIL gmii_good spacing: got %0d bad gaps want 0", obs_gap_bad); end
        n_chk++; if (cnt_start - s_start !== 1) begin n_fail++; $display("FAIL gmii_good start: got %0d want 1", cnt_start - s_start); end
        n_chk++; if (cnt_ef - s_ef !== 0 || cnt_fcs - s_fcs !== 0) begin n_fail++; $display("FAIL gmii_good errors: got %0d/%0d want 0/0", cnt_ef - s_ef, cnt_fcs - s_fcs); end
    endtask

    task automatic test_fcs_corrupt();
        set_mode(1'b0); make_seq(60); snap();
        build_frame(body_q, 1'b1, 10, -1, 1'b0, 1'b0); set_exp(); run_all(); summarize(mark, 1);
        n_chk++; if (obs_n !== 60 || obs_bad !== 0) begin n_fail++; $display("FAIL fcs_corrupt beats: got %0d (%0d wrong) want 60 (0)", obs_n, obs_bad); end
        n_chk++; if (obs_user !== 1'b1) begin n_fail++; $display("FAIL fcs_corrupt tuser: got %b want 1", obs_user); end
        n_chk++; if (cnt_ef_tl - s_eftl !== 1 || cnt_ef - s_ef !== 1) begin n_fail++; $display("FAIL fcs_corrupt bad_frame: got %0d with tlast want 1", cnt_ef_tl - s_eftl); end
        n_chk++; if (cnt_fcs_tl - s_fcstl !== 1 || cnt_fcs - s_fcs !== 1) begin n_fail++; $display("FAIL fcs_corrupt bad_fcs: got %0d with tlast want 1", cnt_fcs_tl - s_fcstl); end
    endtask

    task automatic test_rx_error();
        set_mode(1'b0); make_seq(60); snap();
        build_frame(body_q, 1'b1, -1, 20, 1'b0, 1'b0); set_exp(); run_all(); summarize(mark, 1);
        n_chk++; if (obs_n !== 60 || obs_user !== 1'b1) begin n_fail++; $display("FAIL rx_error tuser: got n=%0d user=%b want 60/1", obs_n, obs_user); end
        n_chk++; if (cnt_ef - s_ef !== 1 || cnt_fcs - s_fcs !== 0) begin n_fail++; $display("FAIL rx_error pulses: got %0d/%0d want 1/0", cnt_ef - s_ef, cnt_fcs - s_fcs); end
    endtask

    task automatic test_mii();
        set_mode(1'b1); add_idle(2); play(-1); make_seq(60); snap();
        build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b0); set_exp(); run_all(); summarize(mark, 10);
        n_chk++; if (obs_n !== 60 || obs_bad !== 0) begin n_fail++; $display("FAIL mii beats: got %0d (%0d wrong) want 60 (0)", obs_n, obs_bad); end
        n_chk++; if (obs_gap_bad !== 0) begin n_fail++; $display("FAIL mii spacing: got %0d bad gaps want 0", obs_gap_bad); end
        n_chk++; if (obs_user !== 1'b0 || cnt_ef - s_ef !== 0) begin n_fail++; $display("FAIL mii tuser: got %b want 0", obs_user); end
        snap();
        build_frame(body_q, 1'b1, -1, -1, 1'b1, 1'b0); set_exp(); run_all(); summarize(mark, 0);
        n_chk++; if (obs_n !== 60 || obs_user !== 1'b1) begin n_fail++; $display("FAIL mii_odd tuser: got n=%0d user=%b want 60/1", obs_n, obs_user); end
        n_chk++; if (cnt_ef - s_ef !== 1 || cnt_fcs - s_fcs !== 0) begin n_fail++; $display("FAIL mii_odd pulses: got %0d/%0d want 1/0", cnt_ef - s_ef, cnt_fcs - s_fcs); end
        set_mode(1'b0); add_idle(2); play(-1);
    endtask

    task automatic test_runts();
        set_mode(1'b0); make_seq(3); snap();
        build_frame(body_q, 1'b0, -1, -1, 1'b0, 1'b0); run_all();
        n_chk++; if (bt_data.size() - mark !== 0) begin n_fail++; $display("FAIL runt3 tvalid: got %0d beats want 0", bt_data.size() - mark); end
        n_chk++; if (cnt_ef - s_ef !== 1) begin n_fail++; $display("FAIL runt3 bad_frame: got %0d want 1", cnt_ef - s_ef); end
        make_seq(36); snap();
        build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b0); set_exp(); run_all(); summarize(mark, 1);
        n_chk++; if (obs_n !== 36 || obs_bad !== 0) begin n_fail++; $display("FAIL runt40 beats: got %0d (%0d wrong) want 36 (0)", obs_n, obs_bad); end
        n_chk++; if (obs_user !== 1'b1 || cnt_fcs - s_fcs !== 0) begin n_fail++; $display("FAIL runt40 tuser: got %b fcs=%0d want 1 fcs=0", obs_user, cnt_fcs - s_fcs); end
    endtask

    task automatic test_discard();
        set_mode(1'b0); make_seq(60); snap();
        build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b1); run_all();
        n_chk++; if (bt_data.size() - mark !== 0) begin n_fail++; $display("FAIL discard beats: got %0d want 0", bt_data.size() - mark); end
        n_chk++; if (cnt_start - s_start !== 0 || cnt_ef - s_ef !== 0 || cnt_fcs - s_fcs !== 0) begin n_fail++; $display("FAIL discard pulses: got %0d/%0d/%0d want 0/0/0", cnt_start - s_start, cnt_ef - s_ef, cnt_fcs - s_fcs); end
    endtask

    task automatic test_reset_midframe();
        int tl;
        set_mode(1'b0); make_seq(60); snap();
        build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b0);
        play(8 + 30);
        rst_ni = 1'b0;
        #1;
        n_chk++; if ({m_axis.tvalid, m_axis.tlast, m_axis.tuser, start_packet_o, error_bad_frame_o, error_bad_fcs_o} !== 6'b0) begin n_fail++; $display("FAIL midreset outputs: got %b want 000000", {m_axis.tvalid, m_axis.tlast, m_axis.tuser, start_packet_o, error_bad_frame_o, error_bad_fcs_o}); end
        sym_q.delete();
        gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        add_idle(4); run_all();
        tl = 0;
        for (int i = mark; i < bt_data.size(); i++) if (bt_last[i] === 1'b1) tl++;
        n_chk++; if (tl !== 0 || cnt_ef - s_ef !== 0) begin n_fail++; $display("FAIL midreset aborted tlast: got %0d tlast %0d err want 0/0", tl, cnt_ef - s_ef); end
        snap();
        build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b0); set_exp(); run_all(); summarize(mark, 1);
        n_chk++; if (obs_n !== 60 || obs_bad !== 0 || obs_user !== 1'b0) begin n_fail++; $display("FAIL midreset next frame: got %0d (%0d wrong) user=%b want 60 (0) 0", obs_n, obs_bad, obs_user); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp1[$], exp2[$];
        set_mode(1'b0); snap();
        make_rand($urandom_range(60, 90)); build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b0); set_exp(); exp1 = exp_q;
        add_idle(1);
        make_rand($urandom_range(60, 90)); build_frame(body_q, 1'b1, -1, -1, 1'b0, 1'b0); set_exp(); exp2 = exp_q;
        run_all();
        exp_q = exp1; summarize(mark, 1);
        n_chk++; if (obs_n !== exp1.size() || obs_bad !== 0 || obs_user !== 1'b0) begin n_fail++; $display("FAIL b2b first: got %0d (%0d wrong) user=%b want %0d (0) 0", obs_n, obs_bad, obs_user, exp1.size()); end
        exp_q = exp2; summarize(mark + obs_n, 1);
        n_chk++; if (obs_n !== exp2.size() || obs_bad !== 0 || obs_user !== 1'b0) begin n_fail++; $display("FAIL b2b second: got %0d (%0d wrong) user=%b want %0d (0) 0", obs_n, obs_bad, obs_user, exp2.size()); end
        n_chk++; if (cnt_start - s_start !== 2 || cnt_ef - s_ef !== 0) begin n_fail++; $display("FAIL b2b pulses: got start=%0d err=%0d want 2/0", cnt_start - s_start, cnt_ef - s_ef); end
    endtask

    task automatic test_random();
        int  len, cor, er;
        bit  odd, bad;
        for (int r = 0; r < 8; r++) begin
            set_mode(1'($urandom)); add_idle(2); play(-1);
            len = $urandom_range(1, 80);
            cor = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + 3) : -1;
            er  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 3) : -1;
            odd = mii_mode && ($urandom_range(0, 3) == 0);
            bad = (cor >= 0) || (er >= 0) || odd || (len + 4 < 64);
            make_rand(len); snap();
            build_frame(body_q, 1'b1, cor, er, odd, 1'b0); set_exp(); run_all(); summarize(mark, 0);
            n_chk++; if (obs_n !== len || obs_bad !== 0 || obs_last !== 1'b1) begin n_fail++; $display("FAIL random[%0d] beats: got %0d (%0d wrong) want %0d", r, obs_n, obs_bad, len); end
            n_chk++; if (obs_user !== bad || cnt_ef - s_ef !== int'(bad)) begin n_fail++; $display("FAIL random[%0d] bad: got user=%b pulses=%0d want %b", r, obs_user, cnt_ef - s_ef, bad); end
            n_chk++; if (cnt_fcs - s_fcs !== int'(cor >= 0)) begin n_fail++; $display("FAIL random[%0d] bad_fcs: got %0d want %0d", r, cnt_fcs - s_fcs, int'(cor >= 0)); end
        end
        set_mode(1'b0); add_idle(2); play(-1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        clk_en_i = 1'b1; mii_select_i = 1'b0;
        repeat (3) @(negedge clk_i);
        test_reset();
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        test_gmii_good();
        test_fcs_corrupt();
        test_rx_error();
        test_mii();
        test_runts();
        test_discard();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gmii_rx_axis.md
# gmii_rx_axis

Receive-side MAC framer that consumes the GMII/MII byte stream from the RGMII PHY interface and produces an AXI4-Stream frame. It sits directly downstream of the RGMII PHY interface, in its `mac_gmii_rx_clk` domain. The block strips the preamble and SFD, checks and removes the FCS, and flags bad frames on `tuser` at `tlast`. It has no backpressure: the consumer must always accept data.

## Interface
- `MIN_FRAME_LENGTH`, default 64: minimum byte count after SFD, FCS included. Shorter frames are marked bad.

- `clk_i` in 1: GMII receive clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `gmii_rxd` in 8: receive data. In MII mode only `[3:0]` is used.
- `gmii_rx_dv` in 1: data valid.
- `gmii_rx_er` in 1: receive error.
- `clk_en_i` in 1: sample enable. Tied high at 1000M; one-in-N at 10/100M.
- `mii_select_i` in 1: 1 selects nibble (10/100M) mode, 0 selects byte mode.
- `m_axis_tdata` out 8: frame byte.
- `m_axis_tvalid` out 1: byte valid for one cycle.
- `m_axis_tlast` out 1: last payload byte.
- `m_axis_tuser` out 1: bad frame, meaningful only with `tlast`.
- `start_packet_o` out 1: one-cycle pulse on SFD detect.
- `error_bad_frame_o` out 1: one-cycle pulse when a frame is bad or a runt.
- `error_bad_fcs_o` out 1: one-cycle pulse on FCS mismatch.

## Operation
- **Input capture.** `gmii_rxd`, `gmii_rx_dv` and `gmii_rx_er` are registered on every `clk_i` edge where `clk_en_i` is 1. All FSM, CRC and delay-line updates occur only on enabled cycles.
- **MII assembly.** `mii_select_i` is latched in IDLE and held for the whole frame.
  - In MII mode the FSM consumes nibbles: `0x5` is preamble and `0xD` is the SFD nibble.
  - After the SFD, nibble pairs form bytes, low nibble first.
  - If `gmii_rx_dv` falls with one nibble pending, the frame is marked bad (odd nibble count) and the pending nibble is discarded.
- **FSM states: IDLE, PREAMBLE, PAYLOAD, DISCARD.**
  - IDLE:
    - dv=1 with `0x55` → PREAMBLE.
    - dv=1 with `0xD5` → PAYLOAD, pulse `start_packet_o`.
    - dv=1 with any other value → DISCARD.
  - PREAMBLE:
    - `0x55` → stay.
    - `0xD5` → PAYLOAD, pulse `start_packet_o`.
    - any other value → DISCARD.
    - dv=0 → IDLE with no error.
  - PAYLOAD:
    - Each byte updates the CRC and enters a 5-entry delay line.
    - When the line is already full, the oldest entry is emitted with `tlast`=0.
    - When dv falls, go to IDLE. If the line is full, emit the oldest entry with `tlast`=1 and `tuser`=bad. The remaining 4 entries are FCS and are discarded.
    - If fewer than 5 bytes were received, nothing is emitted and `error_bad_frame_o` pulses.
  - DISCARD: wait for dv=0, then go to IDLE. No output.
- **CRC-32.** Reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD. Computed over all bytes after SFD, FCS included. The FCS is good iff the final register equals 0xDEBB20E3.
- **Bad frame.** A frame is bad if any of these holds:
  - `gmii_rx_er`=1 on any enabled cycle in PAYLOAD;
  - FCS mismatch;
  - byte count < `MIN_FRAME_LENGTH`;
  - odd nibble count in MII mode.
- **Error pulses.** At frame end `error_bad_frame_o` pulses iff the frame is bad. `error_bad_fcs_o` pulses iff the FCS mismatched, independent of the other causes.
- **Byte counter.** Saturates at 0xFFFF and never wraps.

## Timing
- **Reset.** All outputs are 0, state is IDLE, the delay line is empty, CRC is 0xFFFFFFFF, and the byte counter is 0.
- **Reset mid-frame.** Outputs clear immediately. No `tlast` is produced for the aborted frame. The next frame is received normally.
- **Output registers.** All outputs are registered. `m_axis_tvalid`, `start_packet_o` and both error pulses are high for exactly one `clk_i` cycle and are cleared on the next edge regardless of `clk_en_i`.
- **Latency.**
  - Byte i (0-based after SFD) captured at edge t appears on `m_axis` at edge t'+1, where t' is the capture edge of byte i+5.
  - `tlast` appears at the edge after dv=0 is captured.
  - Error pulses are coincident with `tlast`, or with the dv=0 processing edge for runts.
- **Beat spacing.** Minimum spacing is 1 cycle in GMII mode with `clk_en_i`=1, and 2 enabled cycles in MII mode.
- **Back-to-back frames.** Frames separated by a single dv=0 cycle are both received correctly.

## Test plan
- **GMII good frame.** Input: 7×`0x55`, `0xD5`, bytes `0x00`..`0x3B`, correct FCS, `clk_en_i`=1. Required: 60 beats; `tlast` on `0x3B`; `tuser`=0; one `start_packet_o` pulse; no error pulses.
- **FCS corruption.** Same frame with byte 10 XOR `0x01`. Required: 60 beats; `tuser`=1; `error_bad_fcs_o` and `error_bad_frame_o` each pulse once, with `tlast`.
- **Receive error.** `gmii_rx_er`=1 for one cycle at byte 20, FCS good. Required: `tuser`=1; `error_bad_frame_o` pulses; `error_bad_fcs_o` stays 0.
- **MII mode.** `mii_select_i`=1, `clk_en_i` high 1 in 5 cycles, same frame as nibbles. Required: identical 60 bytes with beats 10 clocks apart. An added trailing nibble gives `tuser`=1.
- **Runts.**
  - SFD followed by 3 bytes: no `tvalid`, one `error_bad_frame_o` pulse.
  - 40-byte frame with good FCS: 36 beats, `tuser`=1.
- **Discard and reset.**
  - Preamble containing `0x57`: no output and no pulses.
  - `rst_ni` low at byte 30 of a frame: all outputs 0 at once; the following good frame yields 60 clean beats.
